psr_stack: RTL and testbench

- Registered, parametrised program status register for the pipelined CPU, written back from the execute/writeback boundary.
- Computes seven flags from an ALU result of width DATA_W and updates them under a per-flag mask.
- Supports direct software writes (move-to-PSR).
- Holds a shadow stack of STACK_DEPTH entries so the PSR is saved on interrupt entry and restored on return.

---
 rtl/psr_pkg.sv | 23 ++
 rtl/psr_flag_gen.sv | 25 ++
 rtl/psr_stack.sv | 100 ++++++++++
 tb/tb_psr_stack.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/psr_pkg.sv
// Shared PSR definitions: flag count, flag bit positions and the status word type.
// Also holds the masked-merge helper used when an ALU result updates the PSR.
package psr_pkg;

  localparam int NFLAGS = 7;

  // The low five positions keep the legacy bit order.
  localparam int FLG_PAR  = 0;
  localparam int FLG_EVEN = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_NZ   = 3;
  localparam int FLG_C    = 4;
  localparam int FLG_N    = 5;
  localparam int FLG_V    = 6;

  typedef logic [NFLAGS-1:0] psr_t;

  function automatic psr_t merge_flags(input psr_t old_flags, input psr_t new_flags,
                                       input psr_t mask);
    return (new_flags & mask) | (old_flags & ~mask);
  endfunction

endpackage

// File: rtl/psr_flag_gen.sv
// Flag generator: derives the seven status flags from an ALU result; purely combinational.
// Latency: none. Backpressure: none.
module psr_flag_gen
  import psr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] res,
  input  logic              carry_in,
  input  logic              ovf_in,
  output psr_t              flags
);

  always_comb begin
    flags           = '0;
    flags[FLG_PAR]  = ^res;
    flags[FLG_EVEN] = ~res[0];
    flags[FLG_ZERO] = (res == '0);
    flags[FLG_NZ]   = (res != '0);
    flags[FLG_C]    = carry_in;
    flags[FLG_N]    = res[DATA_W-1];
    flags[FLG_V]    = ovf_in;
  end

endmodule

// File: rtl/psr_stack.sv
// Program status register with masked ALU update, direct write and a shadow save/restore stack.
// Latency: one cycle from any request to psr/depth/stack_err. Backpressure: none; illegal stack ops set sticky stack_err.
module psr_stack
  import psr_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int STACK_DEPTH = 4,
  localparam int PTR_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] res,
  input  logic              carry_in,
  input  logic              ovf_in,
  input  logic [NFLAGS-1:0] upd_mask,
  input  logic              wr_en,
  input  logic [NFLAGS-1:0] wr_data,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic [NFLAGS-1:0] psr,
  output logic [PTR_W-1:0]  depth,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(STACK_DEPTH);

  psr_t             psr_q, psr_d, new_flags, pop_val;
  psr_t             stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0] depth_q, depth_d, depth_m1;
  logic             err_q, err_d;
  logic             is_full, is_empty, push_ok, pop_ok, err_set;

  psr_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .res      (res),
    .carry_in (carry_in),
    .ovf_in   (ovf_in),
    .flags    (new_flags)
  );

  // A simultaneous push and pop is treated as a conflict: neither takes effect.
  always_comb begin
    is_full  = (depth_q == FULL_CNT);
    is_empty = (depth_q == '0);
    depth_m1 = depth_q - PTR_W'(1);
    push_ok  = push & ~pop & ~is_full;
    pop_ok   = pop & ~push & ~is_empty;
    err_set  = (push & pop) | (push & ~pop & is_full) | (pop & ~push & is_empty);
  end

  always_comb begin
    pop_val = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_m1 == PTR_W'(i)) pop_val = stack_mem[i];
    end
  end

  always_comb begin
    psr_d = psr_q;
    if (pop_ok)         psr_d = pop_val;
    else if (wr_en)     psr_d = wr_data;
    else if (upd_valid) psr_d = merge_flags(psr_q, new_flags, upd_mask);

    depth_d = depth_q;
    if (push_ok)        depth_d = depth_q + PTR_W'(1);
    else if (pop_ok)    depth_d = depth_m1;

    // A new error in the same cycle as a clear keeps the flag set.
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psr_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      psr_q   <= psr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // The pre-update PSR is saved, so a same-cycle write only affects the live register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!rst && push_ok && depth_q == PTR_W'(i)) stack_mem[i] <= psr_q;
    end
  end

  assign psr         = psr_q;
  assign depth       = depth_q;
  assign stack_full  = is_full;
  assign stack_empty = is_empty;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_psr_stack.sv
// Directed-vector bench for psr_stack: a table of one-cycle stimulus records with expected outputs,
// followed by a LIFO save/restore sequence with a small queue model and an idle-hold sequence.
module tb_psr_stack;

  localparam int DATA_W      = 32;
  localparam int STACK_DEPTH = 4;
  localparam int PTR_W       = $clog2(STACK_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, upd_valid, carry_in, ovf_in, wr_en, push, pop, err_clr;
  logic [DATA_W-1:0] res;
  logic [6:0]        upd_mask, wr_data, psr;
  logic [PTR_W-1:0]  depth;
  logic              stack_full, stack_empty, stack_err;

  int checks = 0;
  int errors = 0;

  psr_stack #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .res         (res),
    .carry_in    (carry_in),
    .ovf_in      (ovf_in),
    .upd_mask    (upd_mask),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .push        (push),
    .pop         (pop),
    .err_clr     (err_clr),
    .psr         (psr),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        uv;
    logic [31:0] rs;
    logic        c;
    logic        v;
    logic [6:0]  m;
    logic        we;
    logic [6:0]  wd;
    logic        pu;
    logic        po;
    logic        ec;
    logic [6:0]  e_psr;
    logic [2:0]  e_depth;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic uv, logic [31:0] rs, logic c, logic v,
                              logic [6:0] m, logic we, logic [6:0] wd, logic pu,
                              logic po, logic ec, logic [6:0] ep, logic [2:0] ed,
                              logic ee);
    vec_t t;
    t.rst = r;   t.uv = uv; t.rs = rs; t.c = c;   t.v = v;   t.m = m;
    t.we = we;   t.wd = wd; t.pu = pu; t.po = po; t.ec = ec;
    t.e_psr = ep; t.e_depth = ed; t.e_err = ee;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst = t.rst; upd_valid = t.uv; res = t.rs; carry_in = t.c; ovf_in = t.v;
    upd_mask = t.m; wr_en = t.we; wr_data = t.wd; push = t.pu; pop = t.po;
    err_clr = t.ec;
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic chk_all(input int step, input logic [6:0] ep, input logic [2:0] ed,
                         input logic ee);
    chk("psr", step, 32'(psr), 32'(ep));
    chk("depth", step, 32'(depth), 32'(ed));
    chk("stack_full", step, 32'(stack_full), 32'(ed == 3'(STACK_DEPTH)));
    chk("stack_empty", step, 32'(stack_empty), 32'(ed == 3'd0));
    chk("stack_err", step, 32'(stack_err), 32'(ee));
  endtask

  task automatic idle();
    drive(mk(0, 0, 32'h0, 0, 0, 7'h00, 0, 7'h00, 0, 0, 0, 7'h00, 3'd0, 0));
  endtask

  initial begin
    logic [6:0] model_psr;
    logic [6:0] lifo[$];
    logic [6:0] val;
    logic [6:0] expv;

    idle();
    rst = 1'b1;

    //          rst uv res           c  v  mask   we wd     pu po ec  psr    d     err
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 0, 0, 0, 7'h00, 3'd0, 0));
    vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 7'h7F, 0, 7'h00, 0, 0, 0, 7'h06, 3'd0, 0));
    vecs.push_back(mk(0, 1, 32'h80000001, 1, 1, 7'h7F, 0, 7'h00, 0, 0, 0, 7'h78, 3'd0, 0));
    vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 7'h04, 0, 7'h00, 0, 0, 0, 7'h7C, 3'd0, 0));
    vecs.push_back(mk(0, 1, 32'h0000FFFF, 1, 1, 7'h00, 0, 7'h00, 0, 0, 0, 7'h7C, 3'd0, 0));
    vecs.push_back(mk(0, 1, 32'h7FFFFFFE, 0, 0, 7'h7F, 0, 7'h00, 0, 0, 0, 7'h0A, 3'd0, 0));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 0, 7'h21, 0, 7'h00, 0, 0, 0, 7'h2A, 3'd0, 0));
    // nested saves: each push stores the old psr while a write lands in the live one
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 1, 7'h09, 0, 0, 0, 7'h09, 3'd0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 1, 7'h78, 1, 0, 0, 7'h78, 3'd1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 1, 7'h06, 1, 0, 0, 7'h06, 3'd2, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 1, 7'h7F, 1, 0, 0, 7'h7F, 3'd3, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 1, 7'h11, 1, 0, 0, 7'h11, 3'd4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 1, 0, 0, 7'h11, 3'd4, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 0, 0, 1, 7'h11, 3'd4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 0, 1, 0, 7'h7F, 3'd3, 0));
    vecs.push_back(mk(0, 1, 32'h0,        0, 0, 7'h7F, 0, 7'h00, 0, 1, 0, 7'h06, 3'd2, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 0, 1, 0, 7'h78, 3'd1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 0, 1, 0, 7'h09, 3'd0, 0));
    // underflow: pop dropped, write still applies; error beats a same-cycle clear
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 1, 7'h2A, 0, 1, 0, 7'h2A, 3'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 0, 1, 1, 7'h2A, 3'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 0, 0, 1, 7'h2A, 3'd0, 0));
    // collisions with psr=0x09, depth=1, entry0=0x78
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 1, 7'h78, 0, 0, 0, 7'h78, 3'd0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 1, 7'h09, 1, 0, 0, 7'h09, 3'd1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 1, 1, 0, 7'h09, 3'd1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 1, 7'h55, 0, 1, 0, 7'h78, 3'd0, 1));
    vecs.push_back(mk(0, 1, 32'h0,        0, 0, 7'h7F, 1, 7'h55, 0, 0, 0, 7'h55, 3'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 0, 0, 1, 7'h55, 3'd0, 0));
    // reset in the middle of activity
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 1, 0, 0, 7'h55, 3'd1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 1, 0, 0, 7'h55, 3'd2, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 1, 0, 0, 7'h55, 3'd3, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7'h00, 0, 7'h00, 1, 1, 0, 7'h55, 3'd3, 1));
    vecs.push_back(mk(1, 1, 32'h1,        1, 1, 7'h7F, 1, 7'h33, 1, 0, 0, 7'h00, 3'd0, 0));
    vecs.push_back(mk(0, 1, 32'h00000001, 0, 0, 7'h7F, 0, 7'h00, 0, 0, 0, 7'h09, 3'd0, 0));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].e_psr, vecs[i].e_depth, vecs[i].e_err);
    end

    // LIFO save/restore of pseudo-random values against a queue model
    model_psr = 7'h09;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      val = 7'($urandom_range(0, 127));
      idle();
      wr_en = 1'b1; wr_data = val; push = 1'b1;
      lifo.push_back(model_psr);
      model_psr = val;
      @(posedge clk);
      #1;
      chk_all(100 + i, model_psr, 3'(i + 1), 1'b0);
    end
    for (int i = 0; i < STACK_DEPTH; i++) begin
      idle();
      pop = 1'b1;
      expv = lifo.pop_back();
      @(posedge clk);
      #1;
      chk_all(200 + i, expv, 3'(STACK_DEPTH - 1 - i), 1'b0);
      model_psr = expv;
    end

    // idle cycles must hold all state
    idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all(300 + i, model_psr, 3'd0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
